// File: rtl/gpu_pkg.sv
// Shared GPU pixel-pipeline constants: blitter FSM encodings, bit order and ROM latency.
package gpu_pkg;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_FETCH = 4'b0010;
  localparam logic [3:0] ST_DRAW  = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  // Bitmap words are MSB-first: bit 7 is the leftmost pixel.
  localparam logic [2:0] BIT_FIRST = 3'd7;

  localparam int ROM_LATENCY = 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Row / sub-row / word walker for the bitmap blitter; produces the registered ROM word address.
module blit_addr_gen
  import gpu_pkg::*;
#(
  parameter int BM_W    = 64,
  parameter int BM_H    = 64,
  parameter int BM_NO_W = 5,
  parameter int SCALE_W = 2,
  parameter int ADDR_W  = 16,
  parameter int ROW_W   = cnt_width(BM_H),
  parameter int WORD_W  = cnt_width(BM_W / 8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic [BM_NO_W-1:0] bm_no,
  input  logic [SCALE_W-1:0] scale,
  output logic [ROW_W-1:0]   row,
  output logic [SCALE_W-1:0] sub_row,
  output logic [WORD_W-1:0]  word,
  output logic               last_word,
  output logic [ADDR_W-1:0]  mem_addr
);

  localparam int WPR = BM_W / 8;

  logic [ROW_W-1:0]   row_r, row_s;
  logic [SCALE_W-1:0] sub_r, sub_s;
  logic [WORD_W-1:0]  word_r, word_s;
  logic [ADDR_W-1:0]  base_r, base_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;

  // Next counter values; each row is walked once per sub-row so it is re-fetched.
  always_comb begin
    row_s  = row_r;
    sub_s  = sub_r;
    word_s = word_r;
    base_s = base_r;
    if (start) begin
      row_s  = '0;
      sub_s  = '0;
      word_s = '0;
      base_s = ADDR_W'(bm_no) * ADDR_W'(WPR * BM_H);
    end else if (advance) begin
      if (int'(word_r) == WPR - 1) begin
        word_s = '0;
        if (sub_r == scale) begin
          sub_s = '0;
          row_s = row_r + ROW_W'(1);
        end else begin
          sub_s = sub_r + SCALE_W'(1);
        end
      end else begin
        word_s = word_r + WORD_W'(1);
      end
    end else begin
      word_s = word_r;
    end
    addr_s = base_s + ADDR_W'(row_s) * ADDR_W'(WPR) + ADDR_W'(word_s);
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r  <= '0;
      sub_r  <= '0;
      word_r <= '0;
      base_r <= '0;
      addr_r <= '0;
    end else begin
      row_r  <= row_s;
      sub_r  <= sub_s;
      word_r <= word_s;
      base_r <= base_s;
      addr_r <= addr_s;
    end
  end

  assign row       = row_r;
  assign sub_row   = sub_r;
  assign word      = word_r;
  assign mem_addr  = addr_r;
  assign last_word = (int'(row_r) == BM_H - 1) && (sub_r == scale) && (int'(word_r) == WPR - 1);

endmodule

// File: rtl/bitmap_blit_scaled.sv
// Scaled, clipped 1-bpp bitmap blitter emitting per-pixel coordinates.
// Optional BLIT_OPAQUE_EN adds an opaque mode (every unclipped pixel valid, fg_o carries the bit).
module bitmap_blit_scaled
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BM_W       = 64,
  parameter int BM_H       = 64,
  parameter int BM_NO_W    = 5,
  parameter int SCALE_W    = 2,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] y0,
  input  logic [BM_NO_W-1:0]    bm_no,
  input  logic [SCALE_W-1:0]    scale,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  busy,
  output logic                  done
`ifdef BLIT_OPAQUE_EN
  ,
  input  logic                  opaque,
  output logic                  fg_o
`endif
);

  localparam int ROW_W  = cnt_width(BM_H);
  localparam int WORD_W = cnt_width(BM_W / 8);

  logic [3:0]            state_r;
  logic [1:0]            fetch_cnt_r;
  logic [DATA_WIDTH-1:0] x0_r, y0_r, x_r, y_r;
  logic [SCALE_W-1:0]    scale_r, sx_r;
  logic [7:0]            word_data_r;
  logic [2:0]            bit_r;
  logic                  mem_rd_r, valid_r, busy_r, done_r;
`ifdef BLIT_OPAQUE_EN
  logic                  opaque_r, fg_r;
`endif

  logic [ROW_W-1:0]      row_s;
  logic [SCALE_W-1:0]    sub_row_s;
  logic [WORD_W-1:0]     word_s;
  logic                  last_word_s, start_s, advance_s, last_pix_s, pix_bit_s, show_s;
  logic [15:0]           s_s, col_s, xoff_s, yoff_s;
  logic [DATA_WIDTH:0]   x_s, y_s;

  assign start_s   = (state_r == ST_IDLE) && enable && !done_r;
  assign last_pix_s = (bit_r == 3'd0) && (sx_r == scale_r);
  assign advance_s = (state_r == ST_DRAW) && clk_en && last_pix_s && !last_word_s;

  blit_addr_gen #(
    .BM_W(BM_W), .BM_H(BM_H), .BM_NO_W(BM_NO_W), .SCALE_W(SCALE_W), .ADDR_W(ADDR_W)
  ) u_addr (
    .clk(clk), .reset(reset), .start(start_s), .advance(advance_s), .bm_no(bm_no),
    .scale(scale_r), .row(row_s), .sub_row(sub_row_s), .word(word_s),
    .last_word(last_word_s), .mem_addr(mem_addr)
  );

  // Pixel coordinates carry one extra bit; a set carry means the pixel is off-screen.
  assign s_s       = 16'(scale_r) + 16'd1;
  assign col_s     = 16'(word_s) * 16'd8 + 16'(BIT_FIRST - bit_r);
  assign xoff_s    = col_s * s_s + 16'(sx_r);
  assign yoff_s    = 16'(row_s) * s_s + 16'(sub_row_s);
  assign x_s       = {1'b0, x0_r} + (DATA_WIDTH + 1)'(xoff_s);
  assign y_s       = {1'b0, y0_r} + (DATA_WIDTH + 1)'(yoff_s);
  assign pix_bit_s = word_data_r[bit_r];
`ifdef BLIT_OPAQUE_EN
  assign show_s    = !x_s[DATA_WIDTH] && !y_s[DATA_WIDTH] && (pix_bit_s || opaque_r);
`else
  assign show_s    = !x_s[DATA_WIDTH] && !y_s[DATA_WIDTH] && pix_bit_s;
`endif

  // Control FSM and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      fetch_cnt_r <= 2'd0;
      x0_r        <= '0;
      y0_r        <= '0;
      scale_r     <= '0;
      sx_r        <= '0;
      word_data_r <= 8'd0;
      bit_r       <= 3'd0;
      x_r         <= '0;
      y_r         <= '0;
      mem_rd_r    <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef BLIT_OPAQUE_EN
      opaque_r    <= 1'b0;
      fg_r        <= 1'b0;
`endif
    end else begin
      mem_rd_r <= 1'b0;
      valid_r  <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            x0_r        <= x0;
            y0_r        <= y0;
            scale_r     <= scale;
`ifdef BLIT_OPAQUE_EN
            opaque_r    <= opaque;
`endif
            busy_r      <= 1'b1;
            mem_rd_r    <= 1'b1;
            fetch_cnt_r <= 2'd0;
            state_r     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (int'(fetch_cnt_r) == ROM_LATENCY) begin
            word_data_r <= mem_data;
            bit_r       <= BIT_FIRST;
            sx_r        <= '0;
            fetch_cnt_r <= 2'd0;
            state_r     <= ST_DRAW;
          end else begin
            fetch_cnt_r <= fetch_cnt_r + 2'd1;
          end
        end
        ST_DRAW: begin
          if (clk_en) begin
            valid_r <= show_s;
            if (show_s) begin
              x_r  <= x_s[DATA_WIDTH-1:0];
              y_r  <= y_s[DATA_WIDTH-1:0];
`ifdef BLIT_OPAQUE_EN
              fg_r <= pix_bit_s;
`endif
            end
            if (sx_r == scale_r) begin
              sx_r  <= '0;
              bit_r <= bit_r - 3'd1;
            end else begin
              sx_r  <= sx_r + SCALE_W'(1);
            end
            if (last_pix_s) begin
              if (last_word_s) begin
                state_r <= ST_DONE;
              end else begin
                mem_rd_r <= 1'b1;
                state_r  <= ST_FETCH;
              end
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd = mem_rd_r;
  assign valid  = valid_r;
  assign x_o    = x_r;
  assign y_o    = y_r;
  assign busy   = busy_r;
  assign done   = done_r;
`ifdef BLIT_OPAQUE_EN
  assign fg_o   = fg_r;
`endif

endmodule

// File: tb/tb_bitmap_blit_scaled.sv
// Directed bench for bitmap_blit_scaled with an 8x2 bitmap and a one-cycle-latency ROM model.
module tb_bitmap_blit_scaled;

  logic        clk = 1'b0;
  logic        reset, clk_en, enable;
  logic [7:0]  x0, y0;
  logic [4:0]  bm_no;
  logic [1:0]  scale;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        valid, busy, done;
  logic [7:0]  x_o, y_o;
`ifdef BLIT_OPAQUE_EN
  logic        opaque, fg_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, last_vcyc, done_cyc, min_gap;
  logic [15:0] pix_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] addr_q[$];
  logic        fg_q[$];
  logic [7:0]  rom [64];

  bitmap_blit_scaled #(
    .DATA_WIDTH(8), .BM_W(8), .BM_H(2), .BM_NO_W(5), .SCALE_W(2), .ADDR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable), .x0(x0), .y0(y0),
    .bm_no(bm_no), .scale(scale), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .valid(valid), .x_o(x_o), .y_o(y_o), .busy(busy), .done(done)
`ifdef BLIT_OPAQUE_EN
    , .opaque(opaque), .fg_o(fg_o)
`endif
  );

  always #5 clk = ~clk;

  // ROM answers exactly one clock after the read strobe.
  always @(posedge clk) mem_data <= mem_rd ? rom[mem_addr[5:0]] : 8'h00;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      if (pix_q.size() > 0 && (cyc - last_vcyc) < min_gap) min_gap = cyc - last_vcyc;
      pix_q.push_back({x_o, y_o});
`ifdef BLIT_OPAQUE_EN
      fg_q.push_back(fg_o);
`endif
      last_vcyc = cyc;
    end
    if (mem_rd) addr_q.push_back(mem_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ep(input int x, input int y);
    exp_q.push_back({8'(x), 8'(y)});
  endtask

  task automatic check_list(input string tag);
    check({tag, "_count"}, 32'(pix_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++)
      check(tag, 32'(pix_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_mon();
    pix_q.delete();
    fg_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    min_gap   = 1000;
    last_vcyc = 0;
    done_cyc  = -1;
  endtask

  task automatic run_blit(input int pace, input bit en_busy, input bit en_done);
    bit fin;
    fin = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    enable = 1'b1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      clk_en = ((k % pace) == 0);
      if (en_busy && k == 5) begin
        check("busy_mid", 32'(busy), 32'd1);
        enable = 1'b1;
        x0 = 8'd100;
        y0 = 8'd99;
      end else if (en_done && done) begin
        enable = 1'b1;
        x0 = 8'd200;
        fin = 1'b1;
      end else begin
        enable = 1'b0;
        fin = done;
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    clk_en = 1'b1;
    check("timeout", 32'(fin), 32'd1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic exp_s1();
    exp_q.delete();
    ep(10, 20); ep(17, 20); ep(17, 21);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[6] = 8'h81; rom[7] = 8'h01;
    rom[0] = 8'hFF; rom[1] = 8'hFF;
    reset = 1'b1; clk_en = 1'b0; enable = 1'b0;
    x0 = 8'd10; y0 = 8'd20; bm_no = 5'd3; scale = 2'd0;
`ifdef BLIT_OPAQUE_EN
    opaque = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_xy", 32'({x_o, y_o}), 32'd0);
    check("rst_busy", 32'({busy, done, mem_rd}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // Scenario 1: unscaled 0x81 / 0x01 at (10,20), bitmap 3 at words 6,7.
    run_blit(1, 1'b0, 1'b0);
    exp_s1();
    check_list("s1_pix");
    check("s1_fetches", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check("s1_addr0", 32'(addr_q[0]), 32'd6);
      check("s1_addr1", 32'(addr_q[1]), 32'd7);
    end
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_done_lat", 32'(done_cyc), 32'(last_vcyc + 1));
    check("s1_idle_busy", 32'(busy), 32'd0);
`ifdef BLIT_OPAQUE_EN
    foreach (fg_q[i]) check("s1_fg", 32'(fg_q[i]), 32'd1);
`endif

    // Scenario 2: scale 2, rows re-fetched per sub-row.
    scale = 2'd1;
    run_blit(1, 1'b0, 1'b0);
    exp_q.delete();
    ep(10, 20); ep(11, 20); ep(24, 20); ep(25, 20);
    ep(10, 21); ep(11, 21); ep(24, 21); ep(25, 21);
    ep(24, 22); ep(25, 22); ep(24, 23); ep(25, 23);
    check_list("s2_pix");
    check("s2_fetches", 32'(addr_q.size()), 32'd4);
    if (addr_q.size() == 4) check("s2_addr2", 32'(addr_q[2]), 32'd7);
    check("s2_done_cnt", 32'(done_cnt), 32'd1);

    // Scenario 3: right-edge clipping with a solid bitmap.
    scale = 2'd0; bm_no = 5'd0; x0 = 8'd250;
    run_blit(1, 1'b0, 1'b0);
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) ep(250 + i, 20 + r);
    check_list("s3_pix");
    check("s3_done_cnt", 32'(done_cnt), 32'd1);
    check("s3_hold_x", 32'(x_o), 32'd255);

    // Scenario 4: clk_en every 4th cycle.
    bm_no = 5'd3; x0 = 8'd10;
    run_blit(4, 1'b0, 1'b0);
    exp_s1();
    check_list("s4_pix");
    check("s4_gap_ge4", 32'(min_gap >= 4), 32'd1);

    // Scenario 5: reset mid-word in DRAW.
    clear_mon();
    @(posedge clk); #1;
    enable = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("s5_rst_out", 32'({valid, busy, done, mem_rd}), 32'd0);
    check("s5_rst_xy", 32'({x_o, y_o}), 32'd0);
    check("s5_rst_addr", 32'(mem_addr), 32'd0);
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    check("s5_no_done", 32'(done_cnt), 32'd0);
    check("s5_no_pix", 32'(pix_q.size()), 32'd0);
    run_blit(1, 1'b0, 1'b0);
    exp_s1();
    check_list("s5_restart");
    if (addr_q.size() > 0) check("s5_addr0", 32'(addr_q[0]), 32'd6);

    // Scenario 6: enable while busy and during done is ignored.
    x0 = 8'd10; y0 = 8'd20;
    run_blit(1, 1'b1, 1'b1);
    x0 = 8'd10; y0 = 8'd20;
    exp_s1();
    check_list("s6_pix");
    check("s6_done_cnt", 32'(done_cnt), 32'd1);
    check("s6_no_refetch", 32'(addr_q.size()), 32'd2);
    check("s6_idle_busy", 32'(busy), 32'd0);

`ifdef BLIT_OPAQUE_EN
    begin
      logic [7:0] w;
      opaque = 1'b1;
      run_blit(1, 1'b0, 1'b0);
      exp_q.delete();
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 8; i++) ep(10 + i, 20 + r);
      check_list("op_pix");
      check("op_fg_count", 32'(fg_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < fg_q.size(); i++) begin
        w = (i < 8) ? 8'h81 : 8'h01;
        check("op_fg", 32'(fg_q[i]), 32'(w[7 - (i % 8)]));
      end
      opaque = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
